// File: rtl/bist_circuito_simple_pkg.sv
// Shared definitions for the bist_circuito_simple self-test controller.
//   state_t  : controller state encoding
//   VEC_LAST : last input vector {A,B,C} applied in a run
package bist_circuito_simple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] VEC_LAST = 3'd7;

endpackage

// File: rtl/bist_circuito_simple_golden.sv
// Golden (reference) function of the simple 3-input/2-output circuit.
// Purely combinational.
//   a, b, c : circuit inputs (A is the MSB of the vector)
//   x_exp   : expected x = (A & B) | ~C
//   y_exp   : expected y = ~C
module golden_circuito_simple (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x_exp,
  output logic y_exp
);

  assign x_exp = (a & b) | ~c;
  assign y_exp = ~c;

endmodule

// File: rtl/bist_circuito_simple.sv
// Built-in self-test controller for the simple circuit.
// Applies all 8 vectors {A,B,C}, holds each for SETTLE_CYCLES clocks,
// samples x/y and compares them with the golden function.
//   clk, rst          : clock (rising edge), async active-high reset
//   start             : request a run (ignored while busy)
//   a_o, b_o, c_o     : stimulus to the unit under test
//   x_i, y_i          : response of the unit under test
//   busy, done, pass  : run status; pass = done with no mismatches
//   err_count         : number of mismatching vectors (0..8)
//   first_fail        : vector of the first mismatch, valid when fail_valid
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start, stimulus 000
// ST_SETTLE  | vector applied, settle counter running down
// ST_CHECK   | one cycle: compare x_i/y_i with golden(vec)
// ST_DONE    | results valid and held, stimulus 000; start re-runs
module bist_circuito_simple
  import bist_circuito_simple_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       x_i,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_vec, w_vec_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic [2:0] r_first, w_first_nxt;
  logic       r_fvalid, w_fvalid_nxt;
  logic       r_pass, w_pass_nxt;

  logic       w_x_exp, w_y_exp;
  logic       w_mismatch;
  logic       w_busy;

  golden_circuito_simple u_golden (
    .a     (r_vec[2]),
    .b     (r_vec[1]),
    .c     (r_vec[0]),
    .x_exp (w_x_exp),
    .y_exp (w_y_exp)
  );

  assign w_mismatch = (x_i != w_x_exp) || (y_i != w_y_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_vec    <= 3'd0;
      r_cnt    <= 4'd0;
      r_err    <= 4'd0;
      r_first  <= 3'd0;
      r_fvalid <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_first  <= w_first_nxt;
      r_fvalid <= w_fvalid_nxt;
      r_pass   <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    w_first_nxt  = r_first;
    w_fvalid_nxt = r_fvalid;
    w_pass_nxt   = r_pass;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt  = ST_SETTLE;
          w_vec_nxt    = 3'd0;
          w_cnt_nxt    = CNT_LOAD;
          w_err_nxt    = 4'd0;
          w_first_nxt  = 3'd0;
          w_fvalid_nxt = 1'b0;
          w_pass_nxt   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_err_nxt = r_err + 4'd1;
          if (!r_fvalid) begin
            w_first_nxt  = r_vec;
            w_fvalid_nxt = 1'b1;
          end
        end
        if (r_vec == VEC_LAST) begin
          w_state_nxt = ST_DONE;
          // includes the result of this last check
          w_pass_nxt  = (w_err_nxt == 4'd0);
        end else begin
          w_state_nxt = ST_SETTLE;
          w_vec_nxt   = r_vec + 3'd1;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stimulus follows vec only while a run is active; 000 otherwise.
  assign w_busy = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign busy   = w_busy;
  assign done   = (r_state == ST_DONE);
  assign {a_o, b_o, c_o} = w_busy ? r_vec : 3'd0;

  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;
  assign fail_valid = r_fvalid;

endmodule

// File: tb/tb_bist_circuito_simple.sv
// Testbench for bist_circuito_simple: a default instance driving a
// configurable UUT model, plus SETTLE_CYCLES=1 and =3 instances driving a
// UUT whose response lags its inputs by two clocks.
module tb_bist_circuito_simple;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;   // 0 correct, 1 y stuck-at-0, 2 x = ~C only
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // default instance
  logic a_o, b_o, c_o, x_i, y_i, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic gx, gy;

  bist_circuito_simple dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .x_i(x_i), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_valid(fail_valid)
  );

  golden_circuito_simple u_ref (.a(a_o), .b(b_o), .c(c_o), .x_exp(gx), .y_exp(gy));

  always_comb begin
    x_i = gx;
    y_i = gy;
    case (mode)
      1: y_i = 1'b0;
      2: x_i = ~c_o;
      default: ;
    endcase
  end

  // SETTLE_CYCLES=1 instance with late UUT
  logic a1, b1, c1, busy1, done1, pass1, fv1, g1x, g1y;
  logic [3:0] err1;
  logic [2:0] ff1;
  logic [1:0] p1a, p1b;

  bist_circuito_simple #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a1), .b_o(b1), .c_o(c1), .x_i(p1b[1]), .y_i(p1b[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(ff1), .fail_valid(fv1)
  );

  golden_circuito_simple u_ref1 (.a(a1), .b(b1), .c(c1), .x_exp(g1x), .y_exp(g1y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1a <= 2'b00;
      p1b <= 2'b00;
    end else begin
      p1a <= {g1x, g1y};
      p1b <= p1a;
    end
  end

  // SETTLE_CYCLES=3 instance with the same late UUT
  logic a3, b3, c3, busy3, done3, pass3, fv3, g3x, g3y;
  logic [3:0] err3;
  logic [2:0] ff3;
  logic [1:0] p3a, p3b;

  bist_circuito_simple #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a3), .b_o(b3), .c_o(c3), .x_i(p3b[1]), .y_i(p3b[0]),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail(ff3), .fail_valid(fv3)
  );

  golden_circuito_simple u_ref3 (.a(a3), .b(b3), .c(c3), .x_exp(g3x), .y_exp(g3y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p3a <= 2'b00;
      p3b <= 2'b00;
    end else begin
      p3a <= {g3x, g3y};
      p3b <= p3a;
    end
  end

  // start is sampled on the posedge between the two negedges
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cycles = posedges after the start edge until done is seen
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_o, b_o, c_o, busy, done, pass, err_count, first_fail, fail_valid} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {a_o, b_o, c_o, busy, done, pass, err_count, first_fail, fail_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_clean_run();
    int cycles;
    int bad;
    mode = 0;
    pulse_start();
    cycles = 0;
    bad = 0;
    while (!done && cycles < 200) begin
      if ({a_o, b_o, c_o} !== 3'(cycles / 3) || busy !== 1'b1) bad++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 24) begin
      errors++;
      $display("FAIL clean_latency: got %0d expected 24", cycles);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clean_stimulus_busy: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 4'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_result: pass=%b err=%0d fv=%b expected 1 0 0", pass, err_count, fail_valid);
    end
    checks++;
    if (busy !== 1'b0 || {a_o, b_o, c_o} !== 3'b000) begin
      errors++;
      $display("FAIL clean_done_idle: busy=%b abc=%b expected 0 000", busy, {a_o, b_o, c_o});
    end
  endtask

  task automatic test_y_stuck();
    int cycles;
    mode = 1;
    pulse_start();
    wait_done(cycles);
    checks++;
    if (cycles != 24) begin
      errors++;
      $display("FAIL ystuck_latency: got %0d expected 24", cycles);
    end
    checks++;
    if (err_count !== 4'd4 || first_fail !== 3'b000 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL ystuck_result: err=%0d ff=%b fv=%b pass=%b expected 4 000 1 0",
               err_count, first_fail, fail_valid, pass);
    end
  endtask

  task automatic test_x_missing_ab();
    int cycles;
    mode = 2;
    pulse_start();
    wait_done(cycles);
    checks++;
    if (cycles != 24) begin
      errors++;
      $display("FAIL xnoab_latency: got %0d expected 24", cycles);
    end
    checks++;
    if (err_count !== 4'd1 || first_fail !== 3'b111 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL xnoab_result: err=%0d ff=%b fv=%b pass=%b expected 1 111 1 0",
               err_count, first_fail, fail_valid, pass);
    end
  endtask

  task automatic test_async_reset();
    int cycles;
    mode = 1;
    pulse_start();
    repeat (9) @(negedge clk);
    checks++;
    if ({a_o, b_o, c_o} !== 3'b011 || busy !== 1'b1 || err_count !== 4'd2) begin
      errors++;
      $display("FAIL midrun_state: abc=%b busy=%b err=%0d expected 011 1 2",
               {a_o, b_o, c_o}, busy, err_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_o, b_o, c_o, busy, done, pass, err_count, first_fail, fail_valid} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b expected 0",
               {a_o, b_o, c_o, busy, done, pass, err_count, first_fail, fail_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    pulse_start();
    wait_done(cycles);
    checks++;
    if (cycles != 24 || pass !== 1'b1 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL after_reset_run: lat=%0d pass=%b err=%0d expected 24 1 0", cycles, pass, err_count);
    end
  endtask

  task automatic test_start_while_busy();
    int cycles;
    mode = 0;
    pulse_start();
    cycles = 0;
    while (!done && cycles < 200) begin
      start = (cycles == 10);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles != 24 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: lat=%0d pass=%b expected 24 1", cycles, pass);
    end
  endtask

  task automatic test_start_held();
    int cycles;
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(cycles);
    checks++;
    if (cycles != 24 || err_count !== 4'd4) begin
      errors++;
      $display("FAIL held_first_run: lat=%0d err=%0d expected 24 4", cycles, err_count);
    end
    mode = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL held_restart: done=%b busy=%b err=%0d expected 0 1 0", done, busy, err_count);
    end
    start = 1'b0;
    wait_done(cycles);
    checks++;
    if (cycles != 24 || pass !== 1'b1) begin
      errors++;
      $display("FAIL held_second_run: lat=%0d pass=%b expected 24 1", cycles, pass);
    end
  endtask

  task automatic test_settle_param();
    int cycles;
    int l1;
    int l3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    cycles = 0;
    l1 = -1;
    l3 = -1;
    while ((l1 < 0 || l3 < 0) && cycles < 200) begin
      if (done1 && l1 < 0) l1 = cycles;
      if (done3 && l3 < 0) l3 = cycles;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (l1 != 16) begin
      errors++;
      $display("FAIL settle1_latency: got %0d expected 16", l1);
    end
    checks++;
    if (err1 !== 4'd7 || ff1 !== 3'b001 || fv1 !== 1'b1 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL settle1_result: err=%0d ff=%b fv=%b pass=%b expected 7 001 1 0", err1, ff1, fv1, pass1);
    end
    checks++;
    if (l3 != 32) begin
      errors++;
      $display("FAIL settle3_latency: got %0d expected 32", l3);
    end
    checks++;
    if (err3 !== 4'd0 || fv3 !== 1'b0 || pass3 !== 1'b1) begin
      errors++;
      $display("FAIL settle3_result: err=%0d fv=%b pass=%b expected 0 0 1", err3, fv3, pass3);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_y_stuck();
    test_x_missing_ab();
    test_async_reset();
    test_start_while_busy();
    test_start_held();
    test_settle_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
